mips_gpio_port: RTL and testbench

- Memory-mapped GPIO peripheral that sits on the MIPS core's data bus inside the board wrapper.
- Input side: samples the slide switches, synchronises and debounces them, and presents the value to the CPU.
- Output side: holds the LED value that the CPU writes and drives the board LEDs.
- Sticky change flag with optional interrupt, so software need not poll switch values.

---
 rtl/mips_gpio_port.sv | 104 ++++++++++
 tb/tb_mips_gpio_port.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_gpio_port.sv
// Memory-mapped GPIO for the MIPS data bus: synchronised, debounced switch input,
// CPU-written LED output, and a sticky change flag with optional level interrupt.
module mips_gpio_port #(
    parameter int SW_W            = 9,
    parameter int LED_W           = 10,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] ledr,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic             re,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irq
);

    localparam int CNT_W = 21;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] A_SW     = 2'd0;
    localparam logic [1:0] A_LED    = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    logic [SW_W-1:0]  sync1;
    logic [SW_W-1:0]  sync2;
    logic [SW_W-1:0]  candidate;
    logic [CNT_W-1:0] count;
    logic [SW_W-1:0]  sw_stable;
    logic             changed;
    logic             irq_en;

    logic             accept;
    logic             clr_changed;
    logic [31:0]      rd_mux;

    // Only the low LED_W bits of a bus write are ever stored.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:LED_W];

    // Stage boundary: candidate has been stable for the full window and differs from sw_stable.
    assign accept      = (sync2 == candidate) && !(count < CNT_LAST) && (candidate != sw_stable);
    assign clr_changed = we && (addr == A_STATUS) && wdata[0];

    always_comb begin
        rd_mux = 32'd0;
        case (addr)
            A_SW:     rd_mux = 32'(sw_stable);
            A_LED:    rd_mux = 32'(ledr);
            A_STATUS: rd_mux = {31'd0, changed};
            A_CTRL:   rd_mux = {31'd0, irq_en};
            default:  rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            candidate <= '0;
            count     <= '0;
            sw_stable <= '0;
            changed   <= 1'b0;
            irq_en    <= 1'b0;
            ledr      <= '0;
            rdata     <= 32'd0;
            irq       <= 1'b0;
        end else begin
            // Stage boundary: two-flop synchroniser.
            sync1 <= sw_in;
            sync2 <= sync1;

            // Stage boundary: whole-vector debounce.
            if (sync2 != candidate) begin
                candidate <= sync2;
                count     <= '0;
            end else if (count < CNT_LAST) begin
                count <= count + 1'b1;
            end else if (accept) begin
                sw_stable <= candidate;
            end

            // A new change accepted on the same edge as a clear keeps the flag set.
            if (accept)
                changed <= 1'b1;
            else if (clr_changed)
                changed <= 1'b0;

            if (we && (addr == A_LED))
                ledr <= wdata[LED_W-1:0];
            if (we && (addr == A_CTRL))
                irq_en <= wdata[0];

            // Stage boundary: registered bus read and interrupt.
            if (re)
                rdata <= rd_mux;
            irq <= changed & irq_en;
        end
    end

endmodule

// File: tb/tb_mips_gpio_port.sv
// Self-checking bench for mips_gpio_port: reads are scored through a queue,
// register accesses come from a vector table, debounce/irq corners are hand sequenced.
module tb_mips_gpio_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  sw_in;
    logic [9:0]  ledr;
    logic [1:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       nm;
        logic [31:0] v;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        we;
        logic        re;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [9:0]  exp_led;
    } vec_t;
    vec_t tbl[12];

    mips_gpio_port #(.SW_W(9), .LED_W(10), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .ledr(ledr), .addr(addr),
        .we(we), .re(re), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Read scoreboard: every edge with re=1 must produce the oldest queued expectation.
    always @(posedge clk) begin
        if (re === 1'b1) begin
            #1;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL rd_unexpected: got 0x%08h, expected no read at %0t", rdata, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.nm, rdata, e.v);
            end
        end
    end

    // Tasks start and end on a falling edge; the access lands on the rising edge between.
    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        addr = a;
        re   = 1'b1;
        sb.push_back('{nm, e});
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [8:0] seq[4];
        seq = '{9'd2, 9'd0, 9'd4, 9'd3};

        tbl[0]  = '{1'b1, 1'b0, 2'd1, 32'h0000_03FF, 32'h0,         10'h3FF};
        tbl[1]  = '{1'b0, 1'b1, 2'd1, 32'h0,         32'h0000_03FF, 10'h3FF};
        tbl[2]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF_F155, 32'h0,         10'h155};
        tbl[3]  = '{1'b0, 1'b1, 2'd1, 32'h0,         32'h0000_0155, 10'h155};
        tbl[4]  = '{1'b1, 1'b0, 2'd0, 32'h0000_01FF, 32'h0,         10'h155};
        tbl[5]  = '{1'b0, 1'b1, 2'd0, 32'h0,         32'h0000_0000, 10'h155};
        tbl[6]  = '{1'b1, 1'b1, 2'd1, 32'h0000_00AA, 32'h0000_0155, 10'h0AA};
        tbl[7]  = '{1'b0, 1'b1, 2'd1, 32'h0,         32'h0000_00AA, 10'h0AA};
        tbl[8]  = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 32'h0,         10'h0AA};
        tbl[9]  = '{1'b0, 1'b1, 2'd3, 32'h0,         32'h0000_0001, 10'h0AA};
        tbl[10] = '{1'b1, 1'b0, 2'd3, 32'h0000_0000, 32'h0,         10'h0AA};
        tbl[11] = '{1'b0, 1'b1, 2'd2, 32'h0,         32'h0000_0000, 10'h0AA};

        rst = 1'b1; sw_in = 9'h1FF; addr = 2'd0; we = 1'b0; re = 1'b0; wdata = 32'd0;

        // Reset with switches high
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ledr", {22'd0, ledr}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        rd(2'd2, 32'd0, "rst_changed");          // edge k: first sampling edge
        idle(4);                                 // k+1..k+4
        rd(2'd0, 32'd0, "sw_before_accept");     // k+5
        rd(2'd0, 32'd0, "sw_on_accept_edge");    // k+6: rdata takes the pre-edge value
        rd(2'd0, 32'h1FF, "sw_after_reset");     // k+7
        rd(2'd2, 32'd1, "changed_after_reset");  // k+8
        wr(2'd2, 32'd1);
        rd(2'd2, 32'd0, "changed_cleared");

        // Switch sequence
        for (int i = 0; i < 4; i++) begin
            sw_in = seq[i];
            idle(100);
            rd(2'd0, 32'(seq[i]), "sw_seq");
            rd(2'd2, 32'd1, "seq_changed");
            wr(2'd2, 32'd1);
            rd(2'd2, 32'd0, "seq_cleared");
        end

        // Glitch shorter than the debounce window
        sw_in = 9'd0;
        idle(20);
        wr(2'd2, 32'd1);
        sw_in = 9'd3;
        idle(2);
        sw_in = 9'd0;
        idle(20);
        rd(2'd0, 32'd0, "glitch_sw");
        rd(2'd2, 32'd0, "glitch_changed");

        // Register access table
        for (int i = 0; i < 12; i++) begin
            we = tbl[i].we; re = tbl[i].re; addr = tbl[i].addr; wdata = tbl[i].wdata;
            if (tbl[i].re) sb.push_back('{"tbl_rdata", tbl[i].exp_rd});
            @(negedge clk);
            we = 1'b0; re = 1'b0;
            chk("tbl_ledr", {22'd0, ledr}, {22'd0, tbl[i].exp_led});
        end

        // Interrupt rise follows changed by one cycle
        wr(2'd3, 32'd1);
        sw_in = 9'd5;
        idle(6);
        chk("irq_before_change", {31'd0, irq}, 32'd0);
        idle(1);
        chk("irq_on_change_edge", {31'd0, irq}, 32'd0);
        idle(1);
        chk("irq_rise", {31'd0, irq}, 32'd1);
        wr(2'd2, 32'd1);
        chk("irq_hold_after_clear", {31'd0, irq}, 32'd1);
        idle(1);
        chk("irq_fall", {31'd0, irq}, 32'd0);

        // Clear on the same edge as a new acceptance: set wins
        sw_in = 9'd6;
        idle(6);
        wr(2'd2, 32'd1);
        idle(1);
        chk("irq_after_collision", {31'd0, irq}, 32'd1);
        rd(2'd2, 32'd1, "collision_changed");
        rd(2'd0, 32'd6, "collision_sw");
        wr(2'd2, 32'd1);
        chk("irq_hold_second_clear", {31'd0, irq}, 32'd1);
        idle(1);
        chk("irq_fall_second_clear", {31'd0, irq}, 32'd0);

        // Reset two cycles before acceptance discards the debounce
        sw_in = 9'd1;
        idle(4);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midrst_ledr", {22'd0, ledr}, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        rd(2'd0, 32'd0, "midrst_sw");            // k2
        rd(2'd2, 32'd0, "midrst_changed");       // k2+1: original acceptance edge
        rd(2'd0, 32'd0, "midrst_sw_late");       // k2+2
        idle(3);                                 // k2+3..k2+5
        rd(2'd0, 32'd0, "reaccept_edge_sw");     // k2+6
        rd(2'd0, 32'd1, "reaccept_sw");          // k2+7
        rd(2'd2, 32'd1, "reaccept_changed");     // k2+8

        idle(2);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
